// File: rtl/jogador_automatico_pkg.sv
// Shared definitions for the automatic player: state codes, the stored
// button sequence and the default timing constants.
package jogador_automatico_pkg;

    // State codes, also exported on db_estado
    localparam logic [3:0] ST_OCIOSO      = 4'd0;
    localparam logic [3:0] ST_INICIA      = 4'd1;
    localparam logic [3:0] ST_ESPERA      = 4'd2;
    localparam logic [3:0] ST_APERTA      = 4'd3;
    localparam logic [3:0] ST_SOLTA       = 4'd4;
    localparam logic [3:0] ST_PROXIMA     = 4'd5;
    localparam logic [3:0] ST_AGUARDA_FIM = 4'd6;
    localparam logic [3:0] ST_FIM         = 4'd7;

    // Default timing
    localparam int JOGAR_CICLOS_DEF = 5;
    localparam int PRESS_CICLOS_DEF = 5;
    localparam int GAP_CICLOS_DEF   = 10;
    localparam int N_JOGADAS_DEF    = 16;

    // Stored sequence ROM: one-hot button for each play index
    function automatic logic [3:0] seq_botao(input logic [3:0] idx);
        logic [3:0] b;
        case (idx)
            4'd0:    b = 4'b0001;
            4'd1:    b = 4'b0010;
            4'd2:    b = 4'b0100;
            4'd3:    b = 4'b1000;
            4'd4:    b = 4'b0100;
            4'd5:    b = 4'b0010;
            4'd6:    b = 4'b0001;
            4'd7:    b = 4'b0001;
            4'd8:    b = 4'b0010;
            4'd9:    b = 4'b0010;
            4'd10:   b = 4'b0100;
            4'd11:   b = 4'b0100;
            4'd12:   b = 4'b1000;
            4'd13:   b = 4'b1000;
            4'd14:   b = 4'b0001;
            default: b = 4'b0100;
        endcase
        return b;
    endfunction

    // Rotate a one-hot button left by one: still one-hot, always a different button
    function automatic logic [3:0] rotl1(input logic [3:0] b);
        return {b[2:0], b[3]};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jogador_automatico_contador_tempo.sv
// contador_tempo: loadable down-counter that stops at zero and flags it.
module contador_tempo #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             carga_i,
    input  logic [WIDTH-1:0] valor_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] conta_q, conta_d;

    // Next count: load has priority, otherwise count down and hold at zero
    always_comb begin
        conta_d = conta_q;
        if (carga_i) begin
            conta_d = valor_i;
        end else if (conta_q != '0) begin
            conta_d = conta_q - WIDTH'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conta_q <= '0;
        end else begin
            conta_q <= conta_d;
        end
    end

    assign zero_o = (conta_q == '0);

endmodule

// File: rtl/jogador_automatico.sv
// jogador_automatico: automatic player driving jogar/botoes of the game,
// replaying the stored sequence with growing rounds and reporting the outcome.
// Optional macro ERRO_INJETADO_EN adds erro_rodada: the last play of that
// round presses the wrong (rotated) button.
module jogador_automatico
    import jogador_automatico_pkg::*;
#(
    parameter int JOGAR_CICLOS = JOGAR_CICLOS_DEF,
    parameter int PRESS_CICLOS = PRESS_CICLOS_DEF,
    parameter int GAP_CICLOS   = GAP_CICLOS_DEF,
    parameter int N_JOGADAS    = N_JOGADAS_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       ganhou,
    input  logic       perdeu,
    input  logic       pronto,
`ifdef ERRO_INJETADO_EN
    input  logic [3:0] erro_rodada,
`endif
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic       fim,
    output logic       acertou,
    output logic [3:0] db_rodada,
    output logic [3:0] db_jogada,
    output logic [3:0] db_estado
);

    localparam int         TEMPO_MAX = max3(JOGAR_CICLOS, PRESS_CICLOS, GAP_CICLOS);
    localparam int         TW        = $clog2(TEMPO_MAX) + 1;
    localparam logic [3:0] ULTIMA    = 4'(N_JOGADAS - 1);

    logic [3:0]    state_q, state_d;
    logic [3:0]    rodada_q, rodada_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          acertou_q, acertou_d;
    logic          tempo_carga;
    logic [TW-1:0] tempo_valor;
    logic          tempo_zero;
    logic          em_jogo;
    logic [3:0]    botao_atual;

    // pronto arrives together with ganhou/perdeu and carries no extra information
    logic unused_pronto;
    assign unused_pronto = pronto;

    contador_tempo #(
        .WIDTH(TW)
    ) u_tempo (
        .clk_i  (clock),
        .rst_i  (reset),
        .carga_i(tempo_carga),
        .valor_i(tempo_valor),
        .zero_o (tempo_zero)
    );

    assign em_jogo = (state_q == ST_ESPERA) || (state_q == ST_APERTA) ||
                     (state_q == ST_SOLTA)  || (state_q == ST_PROXIMA);

    // Button for the current play, optionally corrupted on the chosen round
    always_comb begin
        botao_atual = seq_botao(jogada_q);
`ifdef ERRO_INJETADO_EN
        if ((rodada_q == erro_rodada) && (jogada_q == rodada_q)) begin
            botao_atual = rotl1(seq_botao(jogada_q));
        end
`endif
    end

    // FSM next state and round/play/outcome bookkeeping
    always_comb begin
        state_d   = state_q;
        rodada_d  = rodada_q;
        jogada_d  = jogada_q;
        acertou_d = acertou_q;
        case (state_q)
            ST_OCIOSO, ST_FIM: begin
                if (iniciar) begin
                    state_d   = ST_INICIA;
                    rodada_d  = '0;
                    jogada_d  = '0;
                    acertou_d = 1'b0;
                end
            end
            ST_INICIA:  if (tempo_zero) state_d = ST_ESPERA;
            ST_ESPERA:  if (tempo_zero) state_d = ST_APERTA;
            ST_APERTA:  if (tempo_zero) state_d = ST_SOLTA;
            ST_SOLTA:   if (tempo_zero) state_d = ST_PROXIMA;
            ST_PROXIMA: begin
                if (jogada_q < rodada_q) begin
                    jogada_d = jogada_q + 4'd1;
                    state_d  = ST_APERTA;
                end else if (rodada_q < ULTIMA) begin
                    rodada_d = rodada_q + 4'd1;
                    jogada_d = '0;
                    state_d  = ST_APERTA;
                end else begin
                    state_d = ST_AGUARDA_FIM;
                end
            end
            ST_AGUARDA_FIM: begin
                if (perdeu) begin
                    state_d   = ST_FIM;
                    acertou_d = 1'b0;
                end else if (ganhou) begin
                    state_d   = ST_FIM;
                    acertou_d = 1'b1;
                end
            end
            default: state_d = ST_OCIOSO;
        endcase
        // Game verdicts during play override the sequencing above; perdeu wins
        if (em_jogo) begin
            if (perdeu) begin
                state_d   = ST_FIM;
                acertou_d = 1'b0;
            end else if (ganhou) begin
                state_d   = ST_FIM;
                acertou_d = 1'b1;
            end
        end
    end

    // Timer reload on every state change; N cycles in a state means load N-1
    always_comb begin
        tempo_carga = (state_d != state_q);
        case (state_d)
            ST_INICIA:           tempo_valor = TW'(JOGAR_CICLOS - 1);
            ST_APERTA:           tempo_valor = TW'(PRESS_CICLOS - 1);
            ST_ESPERA, ST_SOLTA: tempo_valor = TW'(GAP_CICLOS - 1);
            default:             tempo_valor = '0;
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_OCIOSO;
            rodada_q  <= '0;
            jogada_q  <= '0;
            acertou_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rodada_q  <= rodada_d;
            jogada_q  <= jogada_d;
            acertou_q <= acertou_d;
        end
    end

    // Moore outputs decoded from registered state
    always_comb begin
        jogar     = (state_q == ST_INICIA);
        botoes    = (state_q == ST_APERTA) ? botao_atual : '0;
        ocupado   = (state_q != ST_OCIOSO) && (state_q != ST_FIM);
        fim       = (state_q == ST_FIM);
        acertou   = acertou_q;
        db_rodada = rodada_q;
        db_jogada = jogada_q;
        db_estado = state_q;
    end

endmodule

// File: tb/tb_jogador_automatico.sv
// Testbench for jogador_automatico: expected jogar pulses and button presses
// are queued by the stimulus; a negedge monitor measures each pulse/press
// (value, length, idle gap before it) and checks it against the queue.
module tb_jogador_automatico;

    localparam logic [3:0] E_OCIOSO  = 4'd0;
    localparam logic [3:0] E_INICIA  = 4'd1;
    localparam logic [3:0] E_SOLTA   = 4'd4;
    localparam logic [3:0] E_AGUARDA = 4'd6;
    localparam logic [3:0] E_FIM     = 4'd7;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       ganhou = 1'b0;
    logic       perdeu = 1'b0;
    logic       pronto = 1'b0;
`ifdef ERRO_INJETADO_EN
    logic [3:0] erro_rodada = 4'd2;
`endif
    logic       jogar;
    logic [3:0] botoes;
    logic       ocupado;
    logic       fim;
    logic       acertou;
    logic [3:0] db_rodada;
    logic [3:0] db_jogada;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    jogador_automatico dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .ganhou   (ganhou),
        .perdeu   (perdeu),
        .pronto   (pronto),
`ifdef ERRO_INJETADO_EN
        .erro_rodada(erro_rodada),
`endif
        .jogar    (jogar),
        .botoes   (botoes),
        .ocupado  (ocupado),
        .fim      (fim),
        .acertou  (acertou),
        .db_rodada(db_rodada),
        .db_jogada(db_jogada),
        .db_estado(db_estado)
    );

    // Hand-entered stored sequence
    logic [3:0] seq_tab [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                                 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                 4'b1000, 4'b1000, 4'b0001, 4'b0100};

    typedef struct {
        bit         eh_jogar;
        logic [3:0] btn;
        int         len;   // -1: press cut short, length not checked
        int         gap;   // -1: idle gap not checked
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  presses = 0;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_btn(input int r, input int j);
        logic [3:0] b;
        b = seq_tab[j];
`ifdef ERRO_INJETADO_EN
        if (r == int'(erro_rodada) && j == r) b = {b[2:0], b[3]};
`endif
        return b;
    endfunction

    task automatic push_jogar();
        ev_t e;
        e.eh_jogar = 1'b1; e.btn = 4'b0000; e.len = 5; e.gap = -1;
        q.push_back(e);
    endtask

    task automatic push_press(input logic [3:0] b, input int len, input int gap);
        ev_t e;
        e.eh_jogar = 1'b0; e.btn = b; e.len = len; e.gap = gap;
        q.push_back(e);
    endtask

    // Plays of rounds 0..last_r, stopping at play last_j of the last round
    task automatic push_jogo(input int last_r, input int last_j, input bit aborta);
        for (int r = 0; r <= last_r; r++) begin
            for (int j = 0; j <= ((r < last_r) ? r : last_j); j++) begin
                bit ultimo;
                ultimo = (r == last_r) && (j == last_j);
                push_press(exp_btn(r, j), (aborta && ultimo) ? -1 : 5,
                           (r == 0 && j == 0) ? 10 : 11);
            end
        end
    endtask

    // ---------------- monitor ----------------
    bit         mon_en = 1'b0;
    bit         in_ev = 1'b0;
    bit         ev_jogar;
    logic [3:0] ev_btn;
    int         ev_len;
    int         ev_gap;
    int         idle = 0;

    task automatic fecha_evento();
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL evento_inesperado: got jogar=%b botoes=%b len=%0d expected nothing",
                     ev_jogar, ev_btn, ev_len);
        end else begin
            e = q.pop_front();
            check($sformatf("tipo_evento#%0d", presses), 32'(ev_jogar), 32'(e.eh_jogar));
            if (!e.eh_jogar) begin
                check($sformatf("botao#%0d", presses), 32'(ev_btn), 32'(e.btn));
                presses++;
            end
            if (e.len >= 0) check($sformatf("duracao#%0d", presses), ev_len, e.len);
            if (e.gap >= 0) check($sformatf("intervalo#%0d", presses), ev_gap, e.gap);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if ($isunknown({jogar, botoes}) || !$onehot0(botoes) ||
                (jogar === 1'b1 && botoes !== 4'b0000)) begin
                errors++;
                $display("FAIL exclusividade: got jogar=%b botoes=%b expected one-hot/zero botoes, never with jogar",
                         jogar, botoes);
            end
            if (in_ev) begin
                if ((ev_jogar && jogar === 1'b1) ||
                    (!ev_jogar && jogar !== 1'b1 && botoes === ev_btn)) begin
                    ev_len++;
                end else begin
                    fecha_evento();
                    in_ev = 1'b0;
                    idle  = 0;
                end
            end
            if (!in_ev) begin
                if (jogar === 1'b1) begin
                    in_ev = 1'b1; ev_jogar = 1'b1; ev_btn = 4'b0000; ev_len = 1; ev_gap = idle;
                end else if (botoes !== 4'b0000) begin
                    in_ev = 1'b1; ev_jogar = 1'b0; ev_btn = botoes; ev_len = 1; ev_gap = idle;
                end else begin
                    idle++;
                end
            end
        end
    end

    // ---------------- bounded waits ----------------
    task automatic espera_estado(input logic [3:0] est, input int max, input string nome);
        int n = 0;
        while (db_estado !== est && n < max) begin
            @(negedge clock);
            n++;
        end
        check({"timeout_", nome}, 32'(db_estado), 32'(est));
    endtask

    task automatic espera_aperto(input logic [3:0] r, input logic [3:0] j, input int max, input string nome);
        int n = 0;
        while (!(db_rodada === r && db_jogada === j && botoes !== 4'b0000) && n < max) begin
            @(negedge clock);
            n++;
        end
        check({"timeout_", nome}, 32'(botoes !== 4'b0000 && db_rodada === r && db_jogada === j), 32'd1);
    endtask

    task automatic pulso_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic check_tudo_zero(input string nome);
        check({nome, "_jogar"},   32'(jogar),     32'd0);
        check({nome, "_botoes"},  32'(botoes),    32'd0);
        check({nome, "_ocupado"}, 32'(ocupado),   32'd0);
        check({nome, "_fim"},     32'(fim),       32'd0);
        check({nome, "_acertou"}, 32'(acertou),   32'd0);
        check({nome, "_rodada"},  32'(db_rodada), 32'd0);
        check({nome, "_jogada"},  32'(db_jogada), 32'd0);
        check({nome, "_estado"},  32'(db_estado), 32'(E_OCIOSO));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_tudo_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);

        // Full game: 136 presses, then the game reports ganhou
        push_jogar();
        push_jogo(15, 15, 1'b0);
        pulso_iniciar();
        check("inicio_jogar", 32'(jogar), 32'd1);
        check("inicio_ocupado", 32'(ocupado), 32'd1);
        espera_estado(E_AGUARDA, 4000, "aguarda_fim");
        check("aguarda_ocupado", 32'(ocupado), 32'd1);
        ganhou = 1'b1; pronto = 1'b1;
        @(negedge clock);
        ganhou = 1'b0; pronto = 1'b0;
        check("ganhou_fim", 32'(fim), 32'd1);
        check("ganhou_acertou", 32'(acertou), 32'd1);
        check("ganhou_rodada", 32'(db_rodada), 32'd15);
        check("ganhou_ocupado", 32'(ocupado), 32'd0);
        check("total_apertos", presses, 136);
        check("fila_vazia_1", q.size(), 0);

        // Restart from FIM, then perdeu during round 3 APERTA
        push_jogar();
        push_jogo(3, 0, 1'b1);
        pulso_iniciar();
        check("reinicio_acertou", 32'(acertou), 32'd0);
        check("reinicio_estado", 32'(db_estado), 32'(E_INICIA));
        check("reinicio_fim", 32'(fim), 32'd0);
        espera_aperto(4'd3, 4'd0, 2000, "rodada3");
        perdeu = 1'b1;
        @(negedge clock);
        perdeu = 1'b0;
        check("perdeu_botoes", 32'(botoes), 32'd0);
        check("perdeu_fim", 32'(fim), 32'd1);
        check("perdeu_acertou", 32'(acertou), 32'd0);
        check("perdeu_rodada", 32'(db_rodada), 32'd3);
        check("perdeu_estado", 32'(db_estado), 32'(E_FIM));
        @(negedge clock);
        check("fila_vazia_2", q.size(), 0);

        // Reset in the middle of round 5
        push_jogar();
        push_jogo(5, 2, 1'b1);
        pulso_iniciar();
        espera_aperto(4'd5, 4'd2, 3000, "rodada5");
        reset = 1'b1;
        @(negedge clock);
        check_tudo_zero("reset_meio");
        reset = 1'b0;
        @(negedge clock);
        check("fila_vazia_3", q.size(), 0);

        // Restart after reset begins again at round 0 with button 0001
        push_jogar();
        push_press(4'b0001, 5, 10);
        pulso_iniciar();
        espera_estado(E_SOLTA, 100, "primeira_solta");
        check("restart_rodada", 32'(db_rodada), 32'd0);
        repeat (2) @(negedge clock);
        check("fila_vazia_4", q.size(), 0);

        reset = 1'b1;
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
